// File: rtl/masked_inv_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : masked_inv_sbox_pkg
// Description : Shared types, sizing helpers and GF(2^8) functions for the
//               masked AES inverse S-box. Optional refresh build macro:
//               MASKED_INV_SBOX_REFRESH_EN
// Revision    : 1.0 - initial release
// ============================================================================
package masked_inv_sbox_pkg;

    localparam int NSHARES_DEFAULT = 8;

    function automatic int isw_bytes(input int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int rnd_w(input int n);
`ifdef MASKED_INV_SBOX_REFRESH_EN
        return (isw_bytes(n) + n - 1) * 8;
`else
        return isw_bytes(n) * 8;
`endif
    endfunction

    localparam int ISW_BYTES = isw_bytes(NSHARES_DEFAULT);
    localparam int RND_W     = rnd_w(NSHARES_DEFAULT);

    localparam logic [7:0] INV_AFF_C = 8'h05;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LIN  = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        M4   = 3'd5,
        OUT  = 3'd6
    } state_t;

    // Position of r_ij in the randomness word, pairs (i<j) in lexicographic order.
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_sq8(input logic [7:0] a);
        return gf_mul8(a, a);
    endfunction

    function automatic logic [7:0] inv_aff_lin8(input logic [7:0] y);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/masked_inv_sbox_mul.sv
`default_nettype none
// ============================================================================
// Module      : masked_gf_mul
// Description : Combinational ISW masked multiplier over GF(2^8) (0x11B).
// Revision    : 1.0 - initial release
// ============================================================================
module masked_gf_mul
    import masked_inv_sbox_pkg::*;
#(
    parameter int NSHARES = 8
) (
    input  logic [NSHARES*8-1:0]              i_a,
    input  logic [NSHARES*8-1:0]              i_b,
    input  logic [isw_bytes(NSHARES)*8-1:0]   i_rnd,
    output logic [NSHARES*8-1:0]              o_p
);

    logic [7:0] w_rij;
    logic [7:0] w_rji;

    always_comb begin
        o_p   = '0;
        w_rij = 8'h00;
        w_rji = 8'h00;
        for (int i = 0; i < NSHARES; i++) begin
            o_p[8*i +: 8] = gf_mul8(i_a[8*i +: 8], i_b[8*i +: 8]);
        end
        // r_ji is formed as (r_ij ^ a_i*b_j) ^ a_j*b_i so the cross term never appears unmasked.
        for (int i = 0; i < NSHARES; i++) begin
            for (int j = i + 1; j < NSHARES; j++) begin
                w_rij = i_rnd[8*pair_idx(i, j, NSHARES) +: 8];
                w_rji = (w_rij ^ gf_mul8(i_a[8*i +: 8], i_b[8*j +: 8]))
                        ^ gf_mul8(i_a[8*j +: 8], i_b[8*i +: 8]);
                o_p[8*i +: 8] = o_p[8*i +: 8] ^ w_rij;
                o_p[8*j +: 8] = o_p[8*j +: 8] ^ w_rji;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/masked_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module      : masked_inv_sbox
// Description : Sequential share-masked AES inverse S-box, x^254 via four
//               time-shared ISW multiplications. Optional operand refresh:
//               MASKED_INV_SBOX_REFRESH_EN
// Revision    : 1.0 - initial release
// ============================================================================
module masked_inv_sbox
    import masked_inv_sbox_pkg::*;
#(
    parameter int NSHARES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NSHARES*8-1:0]        share_in,
    input  logic [rnd_w(NSHARES)-1:0]   rnd,
    output logic                        rnd_req,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NSHARES*8-1:0]        share_out
);

    localparam int c_sh_w  = NSHARES * 8;
    localparam int c_isw_w = isw_bytes(NSHARES) * 8;

    state_t            r_state;
    logic [c_sh_w-1:0] r_x;
    logic [c_sh_w-1:0] r_x2;
    logic [c_sh_w-1:0] r_x3;
    logic [c_sh_w-1:0] r_x12;
    logic [c_sh_w-1:0] r_x240;
    logic [c_sh_w-1:0] r_x252;

    logic [c_sh_w-1:0] w_lin;
    logic [c_sh_w-1:0] w_lin_sq;
    logic [c_sh_w-1:0] w_x2_op;
    logic [c_sh_w-1:0] w_op_a;
    logic [c_sh_w-1:0] w_op_b;
    logic [c_sh_w-1:0] w_prod;
    logic [c_sh_w-1:0] w_prod_p4;
    logic [c_sh_w-1:0] w_prod_p16;

    // Affine constant enters share 0 only; squaring is linear so it stays share-wise.
    always_comb begin
        w_lin    = '0;
        w_lin_sq = '0;
        for (int i = 0; i < NSHARES; i++) begin
            w_lin[8*i +: 8]    = inv_aff_lin8(r_x[8*i +: 8]) ^ ((i == 0) ? INV_AFF_C : 8'h00);
            w_lin_sq[8*i +: 8] = gf_sq8(w_lin[8*i +: 8]);
        end
    end

    always_comb begin
        w_prod_p4  = '0;
        w_prod_p16 = '0;
        for (int i = 0; i < NSHARES; i++) begin
            w_prod_p4[8*i +: 8]  = gf_sq8(gf_sq8(w_prod[8*i +: 8]));
            w_prod_p16[8*i +: 8] = gf_sq8(gf_sq8(w_prod_p4[8*i +: 8]));
        end
    end

`ifdef MASKED_INV_SBOX_REFRESH_EN
    always_comb begin
        w_x2_op = r_x2;
        for (int j = 1; j < NSHARES; j++) begin
            w_x2_op[8*j +: 8] = w_x2_op[8*j +: 8] ^ rnd[c_isw_w + 8*(j-1) +: 8];
            w_x2_op[7:0]      = w_x2_op[7:0]      ^ rnd[c_isw_w + 8*(j-1) +: 8];
        end
    end
`else
    assign w_x2_op = r_x2;
`endif

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            M1:      begin w_op_a = w_x2_op; w_op_b = r_x;     end
            M2:      begin w_op_a = r_x12;   w_op_b = r_x3;    end
            M3:      begin w_op_a = r_x240;  w_op_b = r_x12;   end
            M4:      begin w_op_a = r_x252;  w_op_b = w_x2_op; end
            default: begin w_op_a = '0;      w_op_b = '0;      end
        endcase
    end

    masked_gf_mul #(
        .NSHARES (NSHARES)
    ) u_mul (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .i_rnd (rnd[c_isw_w-1:0]),
        .o_p   (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rnd_req   <= 1'b0;
            share_out <= '0;
            r_x       <= '0;
            r_x2      <= '0;
            r_x3      <= '0;
            r_x12     <= '0;
            r_x240    <= '0;
            r_x252    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x      <= share_in;
                        in_ready <= 1'b0;
                        r_state  <= LIN;
                    end
                end
                LIN: begin
                    r_x     <= w_lin;
                    r_x2    <= w_lin_sq;
                    rnd_req <= 1'b1;
                    r_state <= M1;
                end
                M1: begin
                    r_x3    <= w_prod;
                    r_x12   <= w_prod_p4;
                    r_state <= M2;
                end
                M2: begin
                    r_x240  <= w_prod_p16;
                    r_state <= M3;
                end
                M3: begin
                    r_x252  <= w_prod;
                    r_state <= M4;
                end
                M4: begin
                    share_out <= w_prod;
                    out_valid <= 1'b1;
                    rnd_req   <= 1'b0;
                    r_state   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    rnd_req   <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
